// File: rtl/phase_scheduler_pkg.sv
// Shared light-controller state/phase encodings and the state-class helper
// used to pick a duration for each controller state.
package phase_scheduler_pkg;

  typedef enum logic [3:0] {
    ST_ALL_RED        = 4'h0,
    ST_PHASE_1_GREEN  = 4'h1,
    ST_PHASE_1_YELLOW = 4'h2,
    ST_PHASE_2_GREEN  = 4'h3,
    ST_PHASE_2_YELLOW = 4'h4,
    ST_EAST_GREEN     = 4'h5,
    ST_EAST_YELLOW    = 4'h6,
    ST_WEST_GREEN     = 4'h7,
    ST_WEST_YELLOW    = 4'h8,
    ST_MAINTENANCE    = 4'h9
  } light_state_e;

  typedef enum logic [1:0] {
    PH_PHASE_1       = 2'd0,
    PH_PHASE_2       = 2'd1,
    PH_EAST_PRIORITY = 2'd2,
    PH_WEST_PRIORITY = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    CLS_GREEN      = 3'd0,
    CLS_PRIO_GREEN = 3'd1,
    CLS_YELLOW     = 3'd2,
    CLS_RED        = 3'd3,
    CLS_INVALID    = 3'd4
  } state_class_e;

  function automatic state_class_e state_class(input logic [3:0] s);
    state_class_e c;
    case (s)
      ST_PHASE_1_GREEN, ST_PHASE_2_GREEN:                    c = CLS_GREEN;
      ST_EAST_GREEN, ST_WEST_GREEN:                          c = CLS_PRIO_GREEN;
      ST_PHASE_1_YELLOW, ST_PHASE_2_YELLOW,
      ST_EAST_YELLOW, ST_WEST_YELLOW:                        c = CLS_YELLOW;
      ST_ALL_RED, ST_MAINTENANCE:                            c = CLS_RED;
      default:                                               c = CLS_INVALID;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/phase_scheduler_arbiter.sv
// Chooses the phase taken at the next ALL_RED exit: pending east/west
// priority requests, round-robin between them, and normal-phase alternation.
module phase_arbiter
  import phase_scheduler_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   east_req,
  input  logic   west_req,
  input  logic   enter_all_red,
  input  logic   enter_east_green,
  input  logic   enter_west_green,
  output phase_e phase
);

  logic   pend_e_q, pend_e_d;
  logic   pend_w_q, pend_w_d;
  logic   last_prio_q, last_prio_d;
  logic   rr_west_q, rr_west_d;
  phase_e phase_q, phase_d;
  phase_e next_norm_q, next_norm_d;
  logic   want_e_s, want_w_s;

  // A request arriving in the same cycle as its green entry keeps the flag set.
  always_comb begin
    pend_e_d    = east_req | (pend_e_q & ~enter_east_green);
    pend_w_d    = west_req | (pend_w_q & ~enter_west_green);
    want_e_s    = pend_e_q | east_req;
    want_w_s    = pend_w_q | west_req;
    phase_d     = phase_q;
    last_prio_d = last_prio_q;
    rr_west_d   = rr_west_q;
    next_norm_d = next_norm_q;
    if (enter_all_red) begin
      if (!last_prio_q && (want_e_s || want_w_s)) begin
        if (want_e_s && (!want_w_s || !rr_west_q)) begin
          phase_d = PH_EAST_PRIORITY;
        end else begin
          phase_d = PH_WEST_PRIORITY;
        end
        last_prio_d = 1'b1;
        rr_west_d   = ~rr_west_q;
      end else begin
        phase_d     = next_norm_q;
        next_norm_d = (next_norm_q == PH_PHASE_1) ? PH_PHASE_2 : PH_PHASE_1;
        last_prio_d = 1'b0;
      end
    end else begin
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_e_q    <= 1'b0;
      pend_w_q    <= 1'b0;
      last_prio_q <= 1'b0;
      rr_west_q   <= 1'b0;
      phase_q     <= PH_PHASE_1;
      next_norm_q <= PH_PHASE_2;
    end else begin
      pend_e_q    <= pend_e_d;
      pend_w_q    <= pend_w_d;
      last_prio_q <= last_prio_d;
      rr_west_q   <= rr_west_d;
      phase_q     <= phase_d;
      next_norm_q <= next_norm_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/phase_scheduler.sv
// Times each light-controller state in tick pulses, raises timing_done when a
// state expires, and forces maintenance on operator request or detected fault.
module phase_scheduler
  import phase_scheduler_pkg::*;
#(
  parameter int unsigned GREEN_TICKS      = 20,
  parameter int unsigned PRIO_GREEN_TICKS = 10,
  parameter int unsigned YELLOW_TICKS     = 4,
  parameter int unsigned RED_TICKS        = 2,
  parameter int unsigned WDOG_CYCLES      = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] current_state,
  input  logic       east_req,
  input  logic       west_req,
  input  logic       maint_req,
  output logic       timing_done,
  output logic [1:0] phase,
  output logic       maintenance
);

  logic [3:0]   prev_state_q, prev_state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         timing_done_q, timing_done_d;
  logic         maintenance_q, maintenance_d;
  logic         fault_q, fault_d;
  logic         wd_armed_q, wd_armed_d;
  logic [2:0]   wd_cnt_q, wd_cnt_d;
  logic         entry_s, wd_expire_s;
  logic         enter_all_red_s, enter_east_s, enter_west_s;
  logic [7:0]   load_s;
  state_class_e cls_s;
  phase_e       phase_s;

  always_comb begin
    entry_s         = (current_state != prev_state_q);
    cls_s           = state_class(current_state);
    enter_all_red_s = entry_s && (current_state == ST_ALL_RED);
    enter_east_s    = entry_s && (current_state == ST_EAST_GREEN);
    enter_west_s    = entry_s && (current_state == ST_WEST_GREEN);
    case (cls_s)
      CLS_GREEN:      load_s = 8'(GREEN_TICKS);
      CLS_PRIO_GREEN: load_s = 8'(PRIO_GREEN_TICKS);
      CLS_YELLOW:     load_s = 8'(YELLOW_TICKS);
      default:        load_s = 8'(RED_TICKS);
    endcase

    // Entry reload beats a coincident tick; maintenance freezes the count.
    prev_state_d  = current_state;
    timing_done_d = 1'b0;
    if (entry_s) begin
      cnt_d = load_s;
    end else if (!maintenance_q && tick && (cnt_q != 8'd0)) begin
      cnt_d         = cnt_q - 8'd1;
      timing_done_d = (cnt_q == 8'd1);
    end else begin
      cnt_d = cnt_q;
    end

    wd_expire_s = wd_armed_q && !entry_s && (wd_cnt_q >= 3'(WDOG_CYCLES));
    if (maintenance_q || entry_s) begin
      wd_armed_d = 1'b0;
      wd_cnt_d   = 3'd0;
    end else if (timing_done_q) begin
      wd_armed_d = 1'b1;
      wd_cnt_d   = 3'd1;
    end else if (wd_armed_q && (wd_cnt_q < 3'(WDOG_CYCLES))) begin
      wd_armed_d = 1'b1;
      wd_cnt_d   = wd_cnt_q + 3'd1;
    end else begin
      wd_armed_d = wd_armed_q;
      wd_cnt_d   = wd_cnt_q;
    end

    fault_d       = fault_q | (cls_s == CLS_INVALID) | wd_expire_s;
    maintenance_d = maint_req | fault_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state_q  <= ST_ALL_RED;
      cnt_q         <= 8'(RED_TICKS);
      timing_done_q <= 1'b0;
      maintenance_q <= 1'b0;
      fault_q       <= 1'b0;
      wd_armed_q    <= 1'b0;
      wd_cnt_q      <= 3'd0;
    end else begin
      prev_state_q  <= prev_state_d;
      cnt_q         <= cnt_d;
      timing_done_q <= timing_done_d;
      maintenance_q <= maintenance_d;
      fault_q       <= fault_d;
      wd_armed_q    <= wd_armed_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  phase_arbiter u_arbiter (
    .clk              (clk),
    .rst              (rst),
    .east_req         (east_req),
    .west_req         (west_req),
    .enter_all_red    (enter_all_red_s),
    .enter_east_green (enter_east_s),
    .enter_west_green (enter_west_s),
    .phase            (phase_s)
  );

  assign timing_done = timing_done_q;
  assign maintenance = maintenance_q;
  assign phase       = phase_s;

endmodule
